// File: rtl/bp_pkg.sv
// Shared encodings and the 2-bit saturating counter step for the bimodal predictor.
package bp_pkg;

    localparam int CTR_W = 2;

    localparam logic [CTR_W-1:0] SNT     = 2'b00;
    localparam logic [CTR_W-1:0] WNT     = 2'b01;
    localparam logic [CTR_W-1:0] WT      = 2'b10;
    localparam logic [CTR_W-1:0] ST      = 2'b11;
    localparam logic [CTR_W-1:0] CTR_RST = WNT;

    function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                    input logic             taken);
        logic [CTR_W-1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + CTR_W'(1);
        end else begin
            if (ctr != SNT) nxt = ctr - CTR_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Flop array of 2-bit counters: one async read port, one sync read-modify-write port.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [CTR_W-1:0] mem [DEPTH];

    assign rd_ctr = mem[rd_idx];

    // The write port takes the outcome rather than a value, so the saturating
    // step happens here against the stored entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= CTR_RST;
        end else if (wr_en) begin
            mem[wr_idx] <= sat_update(mem[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal BHT: zero-latency lookup with write-through bypass, EX-side training and stats.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_valid_i,
    input  logic [PC_W-1:0]  fetch_pc_i,
    output logic             pred_taken_o,
    output logic             pred_valid_o,
    input  logic             upd_valid_i,
    input  logic [PC_W-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic             upd_pred_i,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CTR_W-1:0] rd_ctr;
    logic [CTR_W-1:0] fwd_ctr;
    logic             same_idx;
    logic             miss;
    logic             unused_pc_bits;

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign upd_idx   = upd_pc_i[IDX_W+1:2];

    // No tag: PCs that alias onto one index deliberately share a counter.
    assign unused_pc_bits = ^{fetch_pc_i[PC_W-1:IDX_W+2], fetch_pc_i[1:0],
                              upd_pc_i[PC_W-1:IDX_W+2], upd_pc_i[1:0]};

    bp_counter_table #(.IDX_W(IDX_W)) u_table (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (fetch_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (upd_valid_i),
        .wr_idx   (upd_idx),
        .wr_taken (upd_taken_i)
    );

    // Same-cycle train of the looked-up entry: forward the value it is about to take.
    assign same_idx = upd_valid_i && (upd_idx == fetch_idx);
    assign fwd_ctr  = same_idx ? sat_update(rd_ctr, upd_taken_i) : rd_ctr;

    assign pred_valid_o = fetch_valid_i & ~rst_i;
    assign pred_taken_o = pred_valid_o & fwd_ctr[1];

    assign miss = upd_pred_i ^ upd_taken_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mispredict_o <= 1'b0;
            branch_cnt_o <= '0;
            miss_cnt_o   <= '0;
        end else if (upd_valid_i) begin
            mispredict_o <= miss;
            if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (miss && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht with hand-computed expectations.
module tb_branch_predictor_bht;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_pc_i = '0;
    logic        pred_taken_o;
    logic        pred_valid_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic        upd_pred_i = 1'b0;
    logic        mispredict_o;
    logic [15:0] branch_cnt_o;
    logic [15:0] miss_cnt_o;

    int compared = 0;
    int mismatched = 0;

    branch_predictor_bht #(.IDX_W(6), .PC_W(32), .CNT_W(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_pc_i    (fetch_pc_i),
        .pred_taken_o  (pred_taken_o),
        .pred_valid_o  (pred_valid_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_pred_i    (upd_pred_i),
        .mispredict_o  (mispredict_o),
        .branch_cnt_o  (branch_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic pred);
        upd_valid_i = 1'b1;
        upd_pc_i    = pc;
        upd_taken_i = taken;
        upd_pred_i  = pred;
        tick();
        upd_valid_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp);
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        #1;
        check(tag, pred_taken_o, exp);
    endtask

    task automatic do_reset();
        upd_valid_i = 1'b0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        // 1: reset state
        rst_i = 1'b1;
        fetch_valid_i = 1'b1;
        #2;
        check("pred_valid_in_reset", pred_valid_o, 1'b0);
        check("mispredict_rst", mispredict_o, 1'b0);
        check("branch_cnt_rst", branch_cnt_o, 16'd0);
        check("miss_cnt_rst", miss_cnt_o, 16'd0);
        do_reset();
        #1;
        check("pred_valid_after_rst", pred_valid_o, 1'b1);
        for (int i = 0; i < 64; i++) look($sformatf("rst_idx%0d", i), 32'(i) << 2, 1'b0);

        // 2: training up and down at 0x40
        upd(32'h40, 1'b1, 1'b0);
        look("t2_wt", 32'h40, 1'b1);
        check("t2_mispredict_set", mispredict_o, 1'b1);
        upd(32'h40, 1'b1, 1'b1);
        look("t2_st", 32'h40, 1'b1);
        check("t2_mispredict_clr", mispredict_o, 1'b0);
        upd(32'h40, 1'b0, 1'b1);
        look("t2_wt_down", 32'h40, 1'b1);
        tick();
        check("t2_mispredict_hold", mispredict_o, 1'b1);
        upd(32'h40, 1'b0, 1'b1);
        look("t2_wnt", 32'h40, 1'b0);

        // 3: saturation at both ends
        repeat (5) upd(32'h40, 1'b1, 1'b1);
        look("t3_sat_hi", 32'h40, 1'b1);
        upd(32'h40, 1'b0, 1'b0);
        look("t3_hi_no_wrap", 32'h40, 1'b1);
        repeat (4) upd(32'h40, 1'b0, 1'b0);
        look("t3_sat_lo", 32'h40, 1'b0);
        upd(32'h40, 1'b1, 1'b1);
        look("t3_lo_no_wrap", 32'h40, 1'b0);

        // 4: same-cycle bypass
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h80;
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h80;
        upd_taken_i   = 1'b1;
        upd_pred_i    = 1'b1;
        #1;
        check("t4_bypass", pred_taken_o, 1'b1);
        fetch_pc_i = 32'h84;
        #1;
        check("t4_no_bypass_other_idx", pred_taken_o, 1'b0);
        tick();
        upd_valid_i = 1'b0;
        look("t4_after_write", 32'h80, 1'b1);
        upd_valid_i = 1'b1;
        upd_taken_i = 1'b0;
        #1;
        check("t4_bypass_down", pred_taken_o, 1'b0);
        tick();
        upd_valid_i = 1'b0;

        // 5: aliasing and ignored PC bits
        upd(32'h004, 1'b1, 1'b1);
        upd(32'h004, 1'b1, 1'b1);
        look("t5_alias_104", 32'h104, 1'b1);
        look("t5_alias_hi_bits", 32'hFFFF_F007, 1'b1);
        look("t5_neighbour", 32'h008, 1'b0);
        fetch_valid_i = 1'b0;
        #1;
        check("t5_no_fetch_pred", pred_taken_o, 1'b0);
        check("t5_no_fetch_valid", pred_valid_o, 1'b0);

        // 6: statistics and asynchronous reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            upd(32'(i) << 2, 1'(i % 2), ((i == 2) || (i == 5) || (i == 7)) ? 1'(~(i % 2)) : 1'(i % 2));
            if (i == 7) check("t6_mispredict_i7", mispredict_o, 1'b1);
        end
        check("t6_branch_cnt", branch_cnt_o, 16'd10);
        check("t6_miss_cnt", miss_cnt_o, 16'd3);
        check("t6_mispredict_last", mispredict_o, 1'b0);
        upd(32'h0C0, 1'b0, 1'b1);
        check("t6_branch_cnt_11", branch_cnt_o, 16'd11);
        check("t6_miss_cnt_4", miss_cnt_o, 16'd4);
        check("t6_mispredict_pre_rst", mispredict_o, 1'b1);
        upd_valid_i = 1'b1;
        upd_pc_i    = 32'h0C0;
        upd_taken_i = 1'b1;
        upd_pred_i  = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_async_branch_cnt", branch_cnt_o, 16'd0);
        check("t6_async_miss_cnt", miss_cnt_o, 16'd0);
        check("t6_async_mispredict", mispredict_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        upd_valid_i = 1'b0;
        rst_i = 1'b0;
        look("t6_inflight_discarded", 32'h0C0, 1'b0);
        look("t6_table_cleared", 32'h004, 1'b0);
        #1;
        check("t6_branch_cnt_post", branch_cnt_o, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
